// File: rtl/spm_seq.sv
// Signed serial-parallel multiplier: x held in parallel, y streamed LSB-first
// through a carry-save cell chain; the 2*WIDTH-bit product is collected serially.
module spm_seq #(
  parameter int WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     x,
  input  logic [WIDTH-1:0]     y,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [2*WIDTH-1:0]   p,
  output logic                 busy
);

  localparam int CNT_W = $clog2(2*WIDTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(2*WIDTH-1);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]           state;
  logic [CNT_W-1:0]     cnt;
  logic [WIDTH-1:0]     x_q;
  logic [WIDTH-1:0]     y_sh;
  logic [WIDTH-1:0]     sum_q;
  logic [WIDTH-1:0]     carry_q;
  logic [WIDTH-1:0]     sum_d;
  logic [WIDTH-1:0]     carry_d;
  logic [2*WIDTH-1:0]   p_sh;
  logic                 yb;
  logic                 pp_sign;

  assign yb = y_sh[0];

  // Unsigned cells: partial product + sum shifted down from cell i+1 + own carry.
  genvar i;
  generate
    for (i = 0; i < WIDTH-1; i++) begin : g_csa
      logic pp;
      assign pp         = x_q[i] & yb;
      assign sum_d[i]   = pp ^ sum_q[i+1] ^ carry_q[i];
      assign carry_d[i] = (pp & sum_q[i+1]) | (pp & carry_q[i]) | (sum_q[i+1] & carry_q[i]);
    end
  endgenerate

  // Sign cell emits the serial two's complement of its partial-product stream:
  // bits pass unchanged until the first 1, then invert; carry_q holds that flag.
  always_comb begin
    pp_sign            = x_q[WIDTH-1] & yb;
    sum_d[WIDTH-1]     = pp_sign ^ carry_q[WIDTH-1];
    carry_d[WIDTH-1]   = pp_sign | carry_q[WIDTH-1];
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= IDLE;
      cnt     <= '0;
      x_q     <= '0;
      y_sh    <= '0;
      sum_q   <= '0;
      carry_q <= '0;
      p_sh    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            x_q     <= x;
            y_sh    <= y;
            sum_q   <= '0;
            carry_q <= '0;
            p_sh    <= '0;
            cnt     <= '0;
            state   <= RUN;
          end
        end
        RUN: begin
          sum_q   <= sum_d;
          carry_q <= carry_d;
          p_sh    <= {sum_d[0], p_sh[2*WIDTH-1:1]};
          y_sh    <= {y_sh[WIDTH-1], y_sh[WIDTH-1:1]};
          cnt     <= cnt + 1'b1;
          if (cnt == CNT_LAST) begin
            state <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_comb begin
    in_ready  = (state == IDLE);
    out_valid = (state == DONE);
    busy      = (state == RUN) || (state == DONE);
    p         = (state == DONE) ? p_sh : '0;
  end

endmodule

// File: doc/spm_seq.md
# spm_seq

Sequential signed serial-parallel multiplier core for the spm datapath. It accepts a WIDTH-bit multiplicand `x` and multiplier `y` over a valid/ready handshake. It streams `y` LSB-first into a chain of WIDTH carry-save cells (the csa0…csaN-1 slices, each built from hsum1/hsum2 half-sum stages) and collects the serial product into a 2·WIDTH-bit result returned over a second valid/ready handshake. The block both drives the CSA chain's serial `y`/`sc` inputs and consumes its serial sum output.

## Interface
- `WIDTH`, default 32: operand width in bits, ≥2. The product is 2·WIDTH bits.
- `clk`  input  1  sole clock; all state updates on the rising edge.
- `rst`  input  1  asynchronous, active-low reset. Assertion clears all state immediately; deassertion is synchronised externally.
- `in_valid`  input  1  operand pair valid.
- `in_ready`  output  1  block can accept operands (IDLE only).
- `x`  input  WIDTH  signed multiplicand, two's complement. Sampled only on input handshake.
- `y`  input  WIDTH  signed multiplier, two's complement. Sampled only on input handshake.
- `out_valid`  output  1  product valid (DONE only).
- `out_ready`  input  1  consumer accepts product.
- `p`  output  2·WIDTH  signed product `x*y`, exact, two's complement.
- `busy`  output  1  high in RUN or DONE.

## Operation
- FSM states: IDLE, RUN, DONE. Reset state is IDLE.
- IDLE:
  - `in_ready`=1.
  - On `in_valid`&&`in_ready`: latch `x` into `x_q` and `y` into shift register `y_sh`.
  - Clear every CSA sum and carry register, clear the product shift register `p_sh`, set `cnt`=0, go to RUN.
- RUN, one serial step per cycle:
  - Serial multiplier bit `yb` = `y_sh[0]`. `y_sh` shifts right arithmetically, so its sign bit replicates after WIDTH steps.
  - Partial product of cell i is `x_q[i] & yb`. Cell WIDTH-1 (the sign cell) subtracts its partial product through the two's-complement path, so the result is the signed product.
  - Each cell adds its partial product, the sum from cell i+1, and its own carry. It registers the new sum and carry.
  - The cell-0 sum bit is the product bit for this step. It shifts into `p_sh` at the MSB end; `p_sh` shifts right.
  - `cnt` increments. When `cnt`==2·WIDTH-1, go to DONE.
- DONE:
  - `out_valid`=1 and `p`=`p_sh`. Both are held stable until `out_ready`.
  - On `out_valid`&&`out_ready`: go to IDLE.
- Arithmetic: `p` equals the mathematical product of signed `x` and `y`, mod 2^(2·WIDTH). For WIDTH≥2 this product is always representable, so no overflow occurs.
- `cnt` is ceil(log2(2·WIDTH)) bits and never wraps inside an operation.
- `in_valid` outside IDLE is ignored. `x`/`y` may change freely after acceptance.
- `out_ready` outside DONE is ignored.
- `p` outputs 0 except in DONE. No partial results are exposed.

## Timing
- Reset values:
  - `in_ready`=1, `out_valid`=0, `busy`=0, `p`=0.
  - `cnt`, `x_q`, `y_sh`, `p_sh` and all CSA sum/carry registers are 0.
- Input handshake at edge E0.
- RUN occupies edges E1..E2W, with W=WIDTH.
- `out_valid` rises after edge E2W, so latency from accept to `out_valid` is 2·WIDTH cycles.
- Output handshake at edge Ed. `in_ready` is 1 after Ed. The next accept is possible at Ed+1 at the earliest.
- With `out_ready` tied high, minimum initiation interval is 2·WIDTH+2 cycles.
- No combinational path from `in_valid` to `in_ready` or from `out_ready` to `out_valid`. All outputs are registered or decoded from state.
- Reset asserted mid-RUN or mid-DONE:
  - All outputs take their reset values asynchronously.
  - The pending product is discarded; no `out_valid` pulse follows.
  - The first operation after reset produces a correct result. No stale carry is carried over.
- `in_valid` and `out_ready` both high in DONE: only the output handshake completes. The input is not accepted in that cycle.

## Test plan
- WIDTH=8, `x`=3, `y`=5, `out_ready`=1 → `out_valid` exactly 16 cycles after accept, `p`=0x000F; `busy` high for 17 cycles.
- WIDTH=8, signed corners:
  - (-128)·(-128) → `p`=0x4000.
  - 127·(-128) → `p`=0xC080.
  - (-1)·1 → `p`=0xFFFF.
  - 0·(-77) → `p`=0x0000.
- WIDTH=8, `x`=-3, `y`=7, `out_ready` low 10 cycles after `out_valid` → `p`=0xFFEB and `out_valid` held stable all 10 cycles. `in_valid` pulses during this time are not accepted (`in_ready`=0).
- WIDTH=8, reset asserted 5 cycles into RUN of 100·100 → outputs return to reset values immediately. A following 7·7 gives `p`=0x0031 at latency 16.
- Back-to-back: `in_valid` and `out_ready` held high, operands 2·3 then (-2)·3 → `p`=0x0006 then `p`=0xFFFA. The second accept occurs exactly one cycle after the first output handshake.
- WIDTH=32 random regression, 10k signed pairs against a reference model → every `p` exact, latency always 64.
